// File: rtl/alu_op_sequencer_if.sv
// ALU-side bus of the command sequencer: command offer (valid/ready) and tagged result return.
//   master : sequencer side (drives alu_valid/alu_cmd/alu_a/alu_b/alu_tag)
//   slave  : ALU side (drives alu_ready/res_valid/res_tag/res_data)
interface alu_op_sequencer_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned RW = 16,
    parameter int unsigned AW = 3
);
    logic          alu_valid;
    logic          alu_ready;
    logic [2:0]    alu_cmd;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [AW-1:0] alu_tag;
    logic          res_valid;
    logic [AW-1:0] res_tag;
    logic [RW-1:0] res_data;

    modport master (
        output alu_valid, alu_cmd, alu_a, alu_b, alu_tag,
        input  alu_ready, res_valid, res_tag, res_data
    );

    modport slave (
        input  alu_valid, alu_cmd, alu_a, alu_b, alu_tag,
        output alu_ready, res_valid, res_tag, res_data
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Command store and issue controller in front of the 8-bit ALU.
// Holds an NSLOT-entry slot file written from the host port; on start, issues
// every slot with R=1 in ascending order, one outstanding command at a time,
// waits for the matching tagged result, then pulses done.
// Word: [23]R [22]C [21:19]addr [18:16]cmd [15:8]a [7:0]b
// Ports: clk, rst_n (async active-low); host: wr_en, wdata, start;
//   status: busy, done, wr_err, last_res, issued_cnt; alu: master modport.
// Optional feature macro ALU_CHAIN_EN: a slot with C=1 takes alu_a from
//   last_res[DW-1:0] instead of its own a field.
module alu_op_sequencer #(
    parameter int unsigned NSLOT = 8,
    parameter int unsigned DW    = 8,
    parameter int unsigned RW    = 16,
    localparam int unsigned AW     = 3,
    localparam int unsigned CW     = 4,
    localparam int unsigned WORD_W = 2 + AW + 3 + 2 * DW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] wdata,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              wr_err,
    alu_op_sequencer_if.master alu,
    output logic [RW-1:0]     last_res,
    output logic [CW-1:0]     issued_cnt
);

    localparam logic [AW-1:0] LAST = AW'(NSLOT - 1);

    typedef struct packed {
        logic          run;
        logic          chain;
        logic [AW-1:0] addr;
        logic [2:0]    cmd;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } slot_t;

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] ptr, ptr_nxt;
    slot_t         slots     [NSLOT];
    slot_t         slots_nxt [NSLOT];
    slot_t         cur, wword;
    logic          busy_nxt, done_nxt, wr_err_nxt, valid_nxt;
    logic [2:0]    cmd_nxt;
    logic [DW-1:0] a_nxt, b_nxt;
    logic [AW-1:0] tag_nxt;
    logic [RW-1:0] last_res_nxt;
    logic [CW-1:0] cnt_nxt;
    logic          unused_bits;

    assign cur   = slots[ptr];
    assign wword = slot_t'(wdata);

    // Stored fields that never drive logic (addr is implied by slot index)
`ifdef ALU_CHAIN_EN
    assign unused_bits = ^cur.addr;
`else
    assign unused_bits = ^{cur.addr, cur.chain};
`endif

    // State and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            ptr           <= '0;
            slots         <= '{default: '0};
            busy          <= 1'b0;
            done          <= 1'b0;
            wr_err        <= 1'b0;
            alu.alu_valid <= 1'b0;
            alu.alu_cmd   <= '0;
            alu.alu_a     <= '0;
            alu.alu_b     <= '0;
            alu.alu_tag   <= '0;
            last_res      <= '0;
            issued_cnt    <= '0;
        end else begin
            state         <= state_nxt;
            ptr           <= ptr_nxt;
            slots         <= slots_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
            wr_err        <= wr_err_nxt;
            alu.alu_valid <= valid_nxt;
            alu.alu_cmd   <= cmd_nxt;
            alu.alu_a     <= a_nxt;
            alu.alu_b     <= b_nxt;
            alu.alu_tag   <= tag_nxt;
            last_res      <= last_res_nxt;
            issued_cnt    <= cnt_nxt;
        end
    end

    // Next-state, slot file update and output values
    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        slots_nxt    = slots;
        wr_err_nxt   = 1'b0;
        valid_nxt    = alu.alu_valid;
        cmd_nxt      = alu.alu_cmd;
        a_nxt        = alu.alu_a;
        b_nxt        = alu.alu_b;
        tag_nxt      = alu.alu_tag;
        last_res_nxt = last_res;
        cnt_nxt      = issued_cnt;

        // Host writes land only while idle; otherwise flag and drop
        if (wr_en) begin
            if (state == S_IDLE) begin
                slots_nxt[wword.addr] = wword;
            end else begin
                wr_err_nxt = 1'b1;
            end
        end

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_SCAN;
                    ptr_nxt   = '0;
                    cnt_nxt   = '0;
                end
            end
            S_SCAN: begin
                if (cur.run) begin
                    state_nxt = S_ISSUE;
                    valid_nxt = 1'b1;
                    cmd_nxt   = cur.cmd;
`ifdef ALU_CHAIN_EN
                    a_nxt     = cur.chain ? last_res[DW-1:0] : cur.a;
`else
                    a_nxt     = cur.a;
`endif
                    b_nxt     = cur.b;
                    tag_nxt   = ptr;
                end else if (ptr == LAST) begin
                    state_nxt = S_DONE;
                end else begin
                    ptr_nxt = ptr + AW'(1);
                end
            end
            S_ISSUE: begin
                if (alu.alu_ready) begin
                    state_nxt = S_WAIT;
                    valid_nxt = 1'b0;
                end
            end
            S_WAIT: begin
                // Results carrying another slot's tag are ignored
                if (alu.res_valid && (alu.res_tag == ptr)) begin
                    last_res_nxt = alu.res_data;
                    if (issued_cnt < CW'(NSLOT)) begin
                        cnt_nxt = issued_cnt + CW'(1);
                    end
                    if (ptr == LAST) begin
                        state_nxt = S_DONE;
                    end else begin
                        ptr_nxt   = ptr + AW'(1);
                        state_nxt = S_SCAN;
                    end
                end
            end
            S_DONE: begin
                for (int i = 0; i < int'(NSLOT); i++) begin
                    slots_nxt[i].run = 1'b0;
                end
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        busy_nxt = (state_nxt != S_IDLE);
        done_nxt = (state_nxt == S_DONE);
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: directed command sets, a scripted ALU
// responder, and a monitor that checks every offered command and every done pulse.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [23:0] wdata;
    logic        start;
    logic        busy, done, wr_err;
    logic [15:0] last_res;
    logic [3:0]  issued_cnt;

    alu_op_sequencer_if #(.DW(8), .RW(16), .AW(3)) alu ();

    alu_op_sequencer #(.NSLOT(8), .DW(8), .RW(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wdata      (wdata),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .wr_err     (wr_err),
        .alu        (alu),
        .last_res   (last_res),
        .issued_cnt (issued_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] tag;
        logic [2:0] cmd;
        logic [7:0] a;
        logic [7:0] b;
    } hs_t;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  cnt;
    } dn_t;

    hs_t exp_hs[$];
    dn_t exp_done[$];
    int  checks = 0;
    int  errors = 0;

    // ALU responder knobs
    int stall_cfg     = 0;
    int res_delay_cfg = 0;
    bit bad_tag_cfg   = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    function automatic logic [23:0] mkw(bit r, bit c, int addr, int cmd, int a, int b);
        return {r, c, 3'(addr), 3'(cmd), 8'(a), 8'(b)};
    endfunction

    function automatic void push_hs(int tag, int cmd, int a, int b);
        hs_t e;
        e.tag = 3'(tag); e.cmd = 3'(cmd); e.a = 8'(a); e.b = 8'(b);
        exp_hs.push_back(e);
    endfunction

    function automatic void push_done(int res, int cnt);
        dn_t e;
        e.res = 16'(res); e.cnt = 4'(cnt);
        exp_done.push_back(e);
    endfunction

    // Scripted ALU: optional ready stall, result delay, and one bogus-tag result first
    initial begin : responder
        int         scnt, dcnt, phase;
        bit         bad_sent;
        logic [2:0] lat_tag;
        logic [15:0] lat_res;
        scnt = 0; dcnt = 0; phase = 0; bad_sent = 1'b0;
        lat_tag = '0; lat_res = '0;
        alu.alu_ready = 1'b0;
        alu.res_valid = 1'b0;
        alu.res_tag   = '0;
        alu.res_data  = '0;
        forever begin
            @(negedge clk);
            alu.res_valid = 1'b0;
            if (!rst_n) begin
                alu.alu_ready = 1'b0;
                phase = 0; scnt = 0; bad_sent = 1'b0;
            end else begin
                if (alu.alu_ready) begin
                    alu.alu_ready = 1'b0;
                    phase = 1;
                    dcnt = 0;
                end else if (phase == 0 && alu.alu_valid) begin
                    if (scnt < stall_cfg) begin
                        scnt++;
                    end else begin
                        alu.alu_ready = 1'b1;
                        scnt = 0;
                        lat_tag = alu.alu_tag;
                        lat_res = 16'(alu.alu_a) + 16'(alu.alu_b);
                    end
                end
                if (phase == 1) begin
                    if (dcnt < res_delay_cfg) begin
                        dcnt++;
                    end else if (bad_tag_cfg && !bad_sent) begin
                        alu.res_valid = 1'b1;
                        alu.res_tag   = lat_tag + 3'd1;
                        alu.res_data  = 16'hDEAD;
                        bad_sent = 1'b1;
                    end else begin
                        alu.res_valid = 1'b1;
                        alu.res_tag   = lat_tag;
                        alu.res_data  = lat_res;
                        phase = 0;
                        bad_sent = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: offered command vs queue head every cycle (stability), pop on accept; done records
    initial begin : monitor
        hs_t e;
        dn_t d;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (alu.alu_valid) begin
                    if (exp_hs.size() == 0) begin
                        chk("unexpected_issue_tag", 32'(alu.alu_tag), 32'hFFFF);
                    end else begin
                        e = exp_hs[0];
                        chk("issue_tag", 32'(alu.alu_tag), 32'(e.tag));
                        chk("issue_cmd", 32'(alu.alu_cmd), 32'(e.cmd));
                        chk("issue_a",   32'(alu.alu_a),   32'(e.a));
                        chk("issue_b",   32'(alu.alu_b),   32'(e.b));
                        if (alu.alu_ready) void'(exp_hs.pop_front());
                    end
                end
                if (done) begin
                    if (exp_done.size() == 0) begin
                        chk("unexpected_done", 32'(done), 32'(0));
                    end else begin
                        d = exp_done.pop_front();
                        chk("done_last_res",   32'(last_res),   32'(d.res));
                        chk("done_issued_cnt", 32'(issued_cnt), 32'(d.cnt));
                    end
                end
            end
        end
    end

    task automatic write_slot(input logic [23:0] w);
        @(negedge clk);
        wr_en = 1'b1;
        wdata = w;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic kick(output int cyc);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #2;
        chk("busy_after_start", 32'(busy), 32'(1));
        cyc = 1;
    endtask

    task automatic wait_done(inout int cyc, output int stalls);
        stalls = 0;
        for (int k = 0; k < 600; k++) begin
            if (done) break;
            @(negedge clk);
            #2;
            cyc++;
            if (alu.alu_valid && !alu.alu_ready) stalls++;
        end
        if (!done) begin
            chk("done_timeout", 32'(done), 32'(1));
        end else begin
            @(negedge clk);
            #2;
            chk("done_one_cycle", 32'(done), 32'(0));
            chk("idle_after_done", 32'(busy), 32'(0));
        end
    endtask

    initial begin : stim
        int cyc, stalls;
        rst_n = 1'b0;
        wr_en = 1'b0;
        wdata = '0;
        start = 1'b0;

        // Reset values
        #12;
        chk("rst_busy",      32'(busy),          32'(0));
        chk("rst_done",      32'(done),          32'(0));
        chk("rst_wr_err",    32'(wr_err),        32'(0));
        chk("rst_valid",     32'(alu.alu_valid), 32'(0));
        chk("rst_tag",       32'(alu.alu_tag),   32'(0));
        chk("rst_a",         32'(alu.alu_a),     32'(0));
        chk("rst_last_res",  32'(last_res),      32'(0));
        chk("rst_issued",    32'(issued_cnt),    32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Single command: 0x0A + 0x03
        write_slot(24'h800A03);
        push_hs(0, 0, 'h0A, 'h03);
        push_done('h000D, 1);
        kick(cyc);
        wait_done(cyc, stalls);
        chk("t1_last_res", 32'(last_res),   32'h000D);
        chk("t1_issued",   32'(issued_cnt), 32'(1));

        // Slots 1,4,7 with a wrong-tag result ahead of every real one
        write_slot(mkw(1, 0, 1, 2, 'h11, 'h22));
        write_slot(mkw(1, 0, 4, 6, 'h40, 'h05));
        write_slot(mkw(1, 0, 7, 7, 'hF0, 'h20));
        push_hs(1, 2, 'h11, 'h22);
        push_hs(4, 6, 'h40, 'h05);
        push_hs(7, 7, 'hF0, 'h20);
        push_done('h0110, 3);
        bad_tag_cfg = 1'b1;
        kick(cyc);
        wait_done(cyc, stalls);
        bad_tag_cfg = 1'b0;

        // R bits cleared: nothing issues, done 9 cycles after start
        push_done('h0110, 0);
        kick(cyc);
        wait_done(cyc, stalls);
        chk("empty_done_latency", 32'(cyc), 32'(9));

        // Write during WAIT is dropped and flagged
        res_delay_cfg = 4;
        write_slot(mkw(1, 0, 2, 3, 'h01, 'h02));
        push_hs(2, 3, 'h01, 'h02);
        push_done('h0003, 1);
        kick(cyc);
        for (int k = 0; k < 40; k++) begin
            if (alu.alu_valid && alu.alu_ready) break;
            @(negedge clk);
            #2;
            cyc++;
        end
        @(negedge clk);
        wr_en = 1'b1;
        wdata = mkw(1, 0, 5, 1, 'h77, 'h77);
        @(negedge clk);
        wr_en = 1'b0;
        #2;
        chk("wr_err_pulse", 32'(wr_err), 32'(1));
        @(negedge clk);
        #2;
        chk("wr_err_clear", 32'(wr_err), 32'(0));
        cyc += 3;
        wait_done(cyc, stalls);
        res_delay_cfg = 0;
        // Slot 5 must still be empty
        push_done('h0003, 0);
        kick(cyc);
        wait_done(cyc, stalls);
        chk("dropped_write_latency", 32'(cyc), 32'(9));

        // ALU holds ready low 5 cycles; monitor checks fields each cycle
        stall_cfg = 5;
        write_slot(mkw(1, 0, 3, 5, 'h5A, 'hA5));
        push_hs(3, 5, 'h5A, 'hA5);
        push_done('h00FF, 1);
        kick(cyc);
        wait_done(cyc, stalls);
        chk("stall_cycles", 32'(stalls), 32'(5));
        stall_cfg = 0;

        // Chained operand
        write_slot(mkw(1, 0, 0, 0, 'h10, 'h02));
        write_slot(mkw(1, 1, 1, 0, 'hFF, 'h01));
        push_hs(0, 0, 'h10, 'h02);
`ifdef ALU_CHAIN_EN
        push_hs(1, 0, 'h12, 'h01);
        push_done('h0013, 2);
`else
        push_hs(1, 0, 'hFF, 'h01);
        push_done('h0100, 2);
`endif
        kick(cyc);
        wait_done(cyc, stalls);

        // Reset asserted while a command is offered
        stall_cfg = 100;
        write_slot(mkw(1, 0, 6, 4, 'h66, 'h01));
        push_hs(6, 4, 'h66, 'h01);
        kick(cyc);
        for (int k = 0; k < 20; k++) begin
            if (alu.alu_valid) break;
            @(negedge clk);
            #2;
        end
        chk("pre_reset_valid", 32'(alu.alu_valid), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("async_valid_drop", 32'(alu.alu_valid), 32'(0));
        chk("async_busy_drop",  32'(busy),          32'(0));
        exp_hs.delete();
        exp_done.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stall_cfg = 0;
        @(negedge clk);
        #2;
        chk("post_rst_busy",     32'(busy),       32'(0));
        chk("post_rst_last_res", 32'(last_res),   32'(0));
        chk("post_rst_issued",   32'(issued_cnt), 32'(0));
        // Slot file cleared: nothing issues
        push_done(0, 0);
        kick(cyc);
        wait_done(cyc, stalls);
        chk("post_rst_latency", 32'(cyc), 32'(9));

        @(negedge clk);
        chk("hs_queue_drained",   32'(exp_hs.size()),   32'(0));
        chk("done_queue_drained", 32'(exp_done.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
